// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the fetch/data bus arbiter.
// State and grant encodings plus the default bus widths.
package bus_arbiter_pkg;

    localparam int RegBus      = 32;
    localparam int InstAddrBus = 32;

    localparam logic [3:0] SelWord = 4'hF;

    typedef enum logic [1:0] {
        ArbIdle    = 2'd0,
        ArbBusyIf  = 2'd1,
        ArbBusyMem = 2'd2,
        ArbDone    = 2'd3
    } arb_state_e;

    typedef enum logic {
        GrantIf  = 1'b0,
        GrantMem = 1'b1
    } grant_e;

    // MEM wins a tie unless it also won last time.
    function automatic grant_e arb_pick(
        input logic   if_req,
        input logic   mem_req,
        input grant_e last
    );
        if (mem_req && !(if_req && last == GrantMem))
            return GrantMem;
        return GrantIf;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester and external bus signals of the arbiter.
// master: arbiter view; slave: requesters plus bus slave view.
interface bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              mem_req_i;
    logic              mem_we_i;
    logic [3:0]        mem_sel_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic              mem_ack_o;
    logic [DATA_W-1:0] mem_rdata_o;

    logic              bus_err_o;
    logic              bus_stb_o;
    logic              bus_we_o;
    logic [3:0]        bus_sel_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic              bus_ack_i;
    logic [DATA_W-1:0] bus_rdata_i;

    logic              stallreq_from_if_o;
    logic              stallreq_from_mem_o;

    modport master (
        input  if_req_i, if_addr_i,
        input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
        input  bus_ack_i, bus_rdata_i,
        output if_ack_o, if_rdata_o,
        output mem_ack_o, mem_rdata_o,
        output bus_err_o, bus_stb_o, bus_we_o, bus_sel_o,
        output bus_addr_o, bus_wdata_o,
        output stallreq_from_if_o, stallreq_from_mem_o
    );

    modport slave (
        output if_req_i, if_addr_i,
        output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
        output bus_ack_i, bus_rdata_i,
        input  if_ack_o, if_rdata_o,
        input  mem_ack_o, mem_rdata_o,
        input  bus_err_o, bus_stb_o, bus_we_o, bus_sel_o,
        input  bus_addr_o, bus_wdata_o,
        input  stallreq_from_if_o, stallreq_from_mem_o
    );

endinterface

// File: rtl/bus_arbiter_watchdog.sv
// Bus timeout counter: runs while a transaction is on the bus,
// clears otherwise, flags the last allowed cycle. TIMEOUT=0 disables it.
module bus_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CW-1:0] Last = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt;

            always_ff @(posedge clk) begin
                if (rst || !run)
                    cnt <= '0;
                else
                    cnt <= cnt + 1'b1;
            end

            assign expire = run && (cnt == Last);
        end
    endgenerate

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter sharing one SRAM-style bus between fetch and MEM.
// Registered bus outputs, one-cycle acks, alternating tie-break, watchdog.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = InstAddrBus,
    parameter int DATA_W  = RegBus,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.master io
);

    arb_state_e state_q, state_d;
    grant_e     last_q;
    grant_e     pick;
    logic       busy;
    logic       expire;
    logic       finish;

    logic              stb_q;
    logic              we_q;
    logic [3:0]        sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              if_ack_q;
    logic              mem_ack_q;
    logic              err_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;

    assign busy   = (state_q == ArbBusyIf) || (state_q == ArbBusyMem);
    assign finish = busy && (io.bus_ack_i || expire);
    assign pick   = arb_pick(io.if_req_i, io.mem_req_i, last_q);

    bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .run   (busy),
        .expire(expire)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ArbIdle: begin
                if (io.if_req_i || io.mem_req_i)
                    state_d = (pick == GrantMem) ? ArbBusyMem : ArbBusyIf;
            end
            ArbBusyIf,
            ArbBusyMem: begin
                if (finish)
                    state_d = ArbDone;
            end
            ArbDone: state_d = ArbIdle;
            default: state_d = ArbIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ArbIdle;
            last_q      <= GrantIf;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            if_ack_q  <= 1'b0;
            mem_ack_q <= 1'b0;
            err_q     <= 1'b0;
            unique case (1'b1)
                state_d == ArbBusyMem && state_q == ArbIdle: begin
                    stb_q   <= 1'b1;
                    we_q    <= io.mem_we_i;
                    sel_q   <= io.mem_sel_i;
                    addr_q  <= io.mem_addr_i;
                    wdata_q <= io.mem_wdata_i;
                end
                state_d == ArbBusyIf && state_q == ArbIdle: begin
                    stb_q   <= 1'b1;
                    we_q    <= 1'b0;
                    sel_q   <= SelWord;
                    addr_q  <= io.if_addr_i;
                    wdata_q <= '0;
                end
                finish: begin
                    // A slave ack on the expiry cycle still counts as success.
                    stb_q <= 1'b0;
                    err_q <= ~io.bus_ack_i;
                    if (state_q == ArbBusyMem) begin
                        mem_ack_q   <= 1'b1;
                        mem_rdata_q <= io.bus_ack_i ? io.bus_rdata_i : '0;
                        last_q      <= GrantMem;
                    end else begin
                        if_ack_q    <= 1'b1;
                        if_rdata_q  <= io.bus_ack_i ? io.bus_rdata_i : '0;
                        last_q      <= GrantIf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.bus_stb_o   = stb_q;
    assign io.bus_we_o    = we_q;
    assign io.bus_sel_o   = sel_q;
    assign io.bus_addr_o  = addr_q;
    assign io.bus_wdata_o = wdata_q;
    assign io.bus_err_o   = err_q;
    assign io.if_ack_o    = if_ack_q;
    assign io.mem_ack_o   = mem_ack_q;
    assign io.if_rdata_o  = if_rdata_q;
    assign io.mem_rdata_o = mem_rdata_q;

    assign io.stallreq_from_if_o  = ~rst & io.if_req_i & ~if_ack_q;
    assign io.stallreq_from_mem_o = ~rst & io.mem_req_i & ~mem_ack_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Random traffic bench for bus_arbiter against a transaction-level model.
// Requesters, slave latency, spurious acks and mid-transfer resets are random.
module tb_bus_arbiter;

    localparam int T    = 4;
    localparam int NCYC = 4000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) io ();

    bus_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (io.master)
    );

    typedef struct {
        logic        req;
        logic        granted;
        int          ack_cyc;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } rq_t;

    typedef struct {
        logic        valid;
        logic        is_mem;
        int          start;
        int          end_stb;
        int          ack_cyc;
        int          d;
        logic        err;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    int n_tests = 0;
    int n_fail  = 0;

    rq_t  rif;
    rq_t  rmem;
    txn_t cur;
    int   arb_cycle;
    logic last_mem;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic new_req(inout rq_t r, input bit is_mem);
        r.req     = 1'b1;
        r.granted = 1'b0;
        r.addr    = $urandom & 32'hFFFF_FFFC;
        if (is_mem) begin
            r.we    = 1'($urandom_range(1, 0));
            r.sel   = 4'($urandom_range(15, 1));
            r.wdata = $urandom;
        end else begin
            r.we    = 1'b0;
            r.sel   = 4'hF;
            r.wdata = 32'h0;
        end
    endtask

    task automatic upd(inout rq_t r, input int n, input bit is_mem);
        if (r.req && r.granted && n == r.ack_cyc + 1) begin
            if ($urandom_range(1, 0) == 1) new_req(r, is_mem);
            else r.req = 1'b0;
        end else if (!r.req && $urandom_range(2, 0) == 0) begin
            new_req(r, is_mem);
        end
    endtask

    task automatic drive_reqs();
        io.if_req_i    = rif.req;
        io.if_addr_i   = rif.addr;
        io.mem_req_i   = rmem.req;
        io.mem_we_i    = rmem.we;
        io.mem_sel_i   = rmem.sel;
        io.mem_addr_i  = rmem.addr;
        io.mem_wdata_i = rmem.wdata;
    endtask

    initial begin
        logic do_rst;
        logic in_win;
        logic w_mem;
        logic w_if;
        logic e_stb;
        logic e_ack;
        logic e_if_ack;
        logic e_mem_ack;

        rif  = '{req: 1'b1, granted: 1'b0, ack_cyc: 0, we: 1'b0,
                 sel: 4'hF, addr: 32'h100, wdata: 32'h0};
        rmem = '{req: 1'b1, granted: 1'b0, ack_cyc: 0, we: 1'b0,
                 sel: 4'hF, addr: 32'h8000, wdata: 32'h0};
        cur       = '{valid: 1'b0, is_mem: 1'b0, start: 0, end_stb: 0,
                      ack_cyc: 0, d: 0, err: 1'b0, we: 1'b0, sel: 4'h0,
                      addr: 32'h0, wdata: 32'h0, rdata: 32'h0};
        arb_cycle = 0;
        last_mem  = 1'b0;

        rst            = 1'b1;
        io.bus_ack_i   = 1'b1;
        io.bus_rdata_i = 32'h1234_5678;
        drive_reqs();

        @(posedge clk);
        @(negedge clk);
        check("rst_stb", 32'(io.bus_stb_o), 32'd0);
        check("rst_if_ack", 32'(io.if_ack_o), 32'd0);
        check("rst_mem_ack", 32'(io.mem_ack_o), 32'd0);
        check("rst_err", 32'(io.bus_err_o), 32'd0);
        check("rst_if_rdata", io.if_rdata_o, 32'd0);
        check("rst_mem_rdata", io.mem_rdata_o, 32'd0);
        check("rst_addr", io.bus_addr_o, 32'd0);
        check("rst_stall_if", 32'(io.stallreq_from_if_o), 32'd0);
        check("rst_stall_mem", 32'(io.stallreq_from_mem_o), 32'd0);

        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            #1;
            if (n > 0) begin
                upd(rif, n, 1'b0);
                upd(rmem, n, 1'b1);
            end

            do_rst = cur.valid && n == cur.start + 1 &&
                     $urandom_range(15, 0) == 0;
            rst = do_rst;

            io.bus_ack_i   = 1'b0;
            io.bus_rdata_i = $urandom;
            in_win = cur.valid && n >= cur.start && n <= cur.end_stb;
            if (in_win) begin
                if (!cur.err && n == cur.start + cur.d) begin
                    io.bus_ack_i   = 1'b1;
                    io.bus_rdata_i = cur.rdata;
                end
            end else if ($urandom_range(7, 0) == 0) begin
                io.bus_ack_i = 1'b1;
            end
            drive_reqs();

            if (!do_rst && n == arb_cycle) begin
                w_mem = rmem.req && !(rif.req && last_mem);
                w_if  = !w_mem && rif.req;
                if (w_mem || w_if) begin
                    cur.valid   = 1'b1;
                    cur.is_mem  = w_mem;
                    cur.start   = n + 1;
                    cur.d       = $urandom_range(5, 0);
                    cur.err     = cur.d >= T;
                    cur.end_stb = cur.start + (cur.err ? T - 1 : cur.d);
                    cur.ack_cyc = cur.end_stb + 1;
                    cur.rdata   = cur.err ? 32'h0 : $urandom;
                    if (w_mem) begin
                        cur.we    = rmem.we;
                        cur.sel   = rmem.sel;
                        cur.addr  = rmem.addr;
                        cur.wdata = rmem.wdata;
                        rmem.granted = 1'b1;
                        rmem.ack_cyc = cur.ack_cyc;
                    end else begin
                        cur.we    = 1'b0;
                        cur.sel   = 4'hF;
                        cur.addr  = rif.addr;
                        cur.wdata = 32'h0;
                        rif.granted = 1'b1;
                        rif.ack_cyc = cur.ack_cyc;
                    end
                    last_mem  = w_mem;
                    arb_cycle = cur.ack_cyc + 1;
                end else begin
                    arb_cycle = n + 1;
                end
            end

            @(negedge clk);
            e_stb     = cur.valid && n >= cur.start && n <= cur.end_stb;
            e_ack     = cur.valid && n == cur.ack_cyc;
            e_if_ack  = e_ack && !cur.is_mem;
            e_mem_ack = e_ack && cur.is_mem;

            check("stb", 32'(io.bus_stb_o), 32'(e_stb));
            if (e_stb) begin
                check("addr", io.bus_addr_o, cur.addr);
                check("we", 32'(io.bus_we_o), 32'(cur.we));
                check("sel", 32'(io.bus_sel_o), 32'(cur.sel));
                check("wdata", io.bus_wdata_o, cur.wdata);
            end
            check("if_ack", 32'(io.if_ack_o), 32'(e_if_ack));
            check("mem_ack", 32'(io.mem_ack_o), 32'(e_mem_ack));
            check("err", 32'(io.bus_err_o), 32'(e_ack && cur.err));
            if (e_if_ack) check("if_rdata", io.if_rdata_o, cur.rdata);
            if (e_mem_ack) check("mem_rdata", io.mem_rdata_o, cur.rdata);
            check("stall_if", 32'(io.stallreq_from_if_o),
                  32'(!rst && rif.req && !e_if_ack));
            check("stall_mem", 32'(io.stallreq_from_mem_o),
                  32'(!rst && rmem.req && !e_mem_ack));

            if (do_rst) begin
                cur.valid    = 1'b0;
                arb_cycle    = n + 1;
                last_mem     = 1'b0;
                rif.granted  = 1'b0;
                rmem.granted = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
